// File: rtl/bpu_update.sv
// Update side of the branch target tag store / gshare predictor: buffers resolved
// branches, drains them into the tag-store and PHT write ports, and tracks committed history.
module bpu_update #(
   parameter int GHR_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             br_valid,
   input  logic [29:0]      br_pc,
   input  logic [GHR_W-1:0] br_index,
   input  logic             br_hit,
   input  logic             br_taken,
   input  logic             br_mispred,
   output logic             br_ready,
   input  logic             upd_stall,
   output logic             btb_wen,
   output logic [GHR_W-1:0] btb_index_w,
   output logic [29:0]      btb_pc_w,
   output logic             pht_wen,
   output logic [GHR_W-1:0] pht_index,
   output logic             pht_taken,
   output logic [GHR_W-1:0] ghr_commit,
   output logic             ghr_restore_valid,
   output logic [GHR_W-1:0] ghr_restore,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 30 + GHR_W + 2;
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [EW-1:0]    r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [GHR_W-1:0] r_ghr;
   logic [GHR_W-1:0] r_restore;
   logic             r_restore_vld;

   logic             w_empty;
   logic             w_full;
   logic             w_push;
   logic             w_pop;
   logic [EW-1:0]    w_head;
   logic [GHR_W-1:0] w_ghr_next;

   // Extra pointer MSB distinguishes full from empty when the address bits match.
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_push     = br_valid && !w_full;
   assign w_pop      = !w_empty && !upd_stall;
   assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
   assign w_ghr_next = {r_ghr[GHR_W-2:0], br_taken};

   // Payload storage carries no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {br_pc, br_index, br_hit, br_taken};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // History follows acceptance order, independent of how fast the FIFO drains.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ghr         <= '0;
         r_restore     <= '0;
         r_restore_vld <= 1'b0;
      end else begin
         r_restore_vld <= w_push && br_mispred;
         if (w_push) r_ghr <= w_ghr_next;
         if (w_push && br_mispred) r_restore <= w_ghr_next;
      end
   end

   assign br_ready          = !w_full;
   assign busy              = !w_empty;
   assign pht_wen           = w_pop;
   assign pht_index         = w_head[GHR_W+1:2];
   assign pht_taken         = w_head[0];
   assign btb_wen           = w_pop && !w_head[1];
   assign btb_index_w       = w_head[GHR_W+1:2];
   assign btb_pc_w          = w_head[EW-1 -: 30];
   assign ghr_commit        = r_ghr;
   assign ghr_restore_valid = r_restore_vld;
   assign ghr_restore       = r_restore;

endmodule

// File: tb/tb_bpu_update.sv
// Scoreboard bench for bpu_update: accepted branches are queued as expected drain
// records and a negedge monitor compares every cycle against the reference model.
module tb_bpu_update;

   localparam int GHR_W = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             br_valid = 1'b0;
   logic [29:0]      br_pc = '0;
   logic [GHR_W-1:0] br_index = '0;
   logic             br_hit = 1'b0;
   logic             br_taken = 1'b0;
   logic             br_mispred = 1'b0;
   logic             br_ready;
   logic             upd_stall = 1'b0;
   logic             btb_wen;
   logic [GHR_W-1:0] btb_index_w;
   logic [29:0]      btb_pc_w;
   logic             pht_wen;
   logic [GHR_W-1:0] pht_index;
   logic             pht_taken;
   logic [GHR_W-1:0] ghr_commit;
   logic             ghr_restore_valid;
   logic [GHR_W-1:0] ghr_restore;
   logic             busy;

   bpu_update #(.GHR_W(GHR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .br_valid(br_valid), .br_pc(br_pc),
      .br_index(br_index), .br_hit(br_hit), .br_taken(br_taken),
      .br_mispred(br_mispred), .br_ready(br_ready), .upd_stall(upd_stall),
      .btb_wen(btb_wen), .btb_index_w(btb_index_w), .btb_pc_w(btb_pc_w),
      .pht_wen(pht_wen), .pht_index(pht_index), .pht_taken(pht_taken),
      .ghr_commit(ghr_commit), .ghr_restore_valid(ghr_restore_valid),
      .ghr_restore(ghr_restore), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [29:0]      pc;
      logic [GHR_W-1:0] idx;
      logic             hit;
      logic             taken;
   } ent_t;

   ent_t sbq[$];
   int   m_ghr = 0;
   logic m_rv = 1'b0;
   int   m_restore = 0;
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares outputs with the model in the middle of each cycle.
   int   mon_cnt;
   logic mon_pop;
   always @(negedge clk) begin
      if (!reset) begin
         mon_cnt = sbq.size();
         mon_pop = (mon_cnt != 0) && !upd_stall;
         chk("busy", 32'(busy), 32'(mon_cnt != 0));
         chk("br_ready", 32'(br_ready), 32'(mon_cnt < DEPTH));
         chk("pht_wen", 32'(pht_wen), 32'(mon_pop));
         if (mon_cnt != 0) begin
            chk("btb_index_w", 32'(btb_index_w), 32'(sbq[0].idx));
            chk("btb_pc_w", 32'(btb_pc_w), 32'(sbq[0].pc));
            chk("btb_wen", 32'(btb_wen), 32'(mon_pop && !sbq[0].hit));
            if (mon_pop) begin
               chk("pht_index", 32'(pht_index), 32'(sbq[0].idx));
               chk("pht_taken", 32'(pht_taken), 32'(sbq[0].taken));
               void'(sbq.pop_front());
            end
         end else begin
            chk("btb_wen_idle", 32'(btb_wen), 32'd0);
         end
         chk("ghr_commit", 32'(ghr_commit), 32'(m_ghr));
         chk("ghr_restore_valid", 32'(ghr_restore_valid), 32'(m_rv));
         chk("ghr_restore", 32'(ghr_restore), 32'(m_restore));
      end
   end

   // Acceptance recorder: pushes expected drain records and advances the history model.
   ent_t rec_e;
   always @(negedge clk) begin
      #2;
      if (!reset) begin
         if (br_valid && br_ready) begin
            rec_e.pc    = br_pc;
            rec_e.idx   = br_index;
            rec_e.hit   = br_hit;
            rec_e.taken = br_taken;
            sbq.push_back(rec_e);
            m_ghr = (m_ghr * 2 + (br_taken ? 1 : 0)) % 256;
            m_rv  = br_mispred;
            if (br_mispred) m_restore = m_ghr;
         end else begin
            m_rv = 1'b0;
         end
      end
   end

   task automatic idle(input int n);
      br_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [29:0] pc, input logic [7:0] idx,
                       input logic hit, input logic taken, input logic mis);
      logic acc;
      acc        = 1'b0;
      br_valid   = 1'b1;
      br_pc      = pc;
      br_index   = idx;
      br_hit     = hit;
      br_taken   = taken;
      br_mispred = mis;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         acc = br_ready;
         @(posedge clk);
         #1;
         if (acc) break;
      end
      if (!acc) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: pc 0x%0h not accepted within 100 cycles", pc);
      end
      br_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sbq.delete();
      m_ghr = 0;
      m_rv = 1'b0;
      m_restore = 0;
      @(negedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   logic held;
   initial begin
      #2;
      chk("rst_br_ready", 32'(br_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_btb_wen", 32'(btb_wen), 32'd0);
      chk("rst_pht_wen", 32'(pht_wen), 32'd0);
      chk("rst_ghr", 32'(ghr_commit), 32'd0);
      chk("rst_restore_valid", 32'(ghr_restore_valid), 32'd0);
      chk("rst_restore", 32'(ghr_restore), 32'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;

      // Single miss update
      send(30'h1234, 8'h5A, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("miss_btb_wen", 32'(btb_wen), 32'd1);
      chk("miss_btb_index", 32'(btb_index_w), 32'h5A);
      chk("miss_btb_pc", 32'(btb_pc_w), 32'h1234);
      chk("miss_pht_wen", 32'(pht_wen), 32'd1);
      chk("miss_pht_taken", 32'(pht_taken), 32'd1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("miss_busy_after", 32'(busy), 32'd0);
      @(posedge clk);
      #1;

      // Hit suppression
      send(30'h2222, 8'h33, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("hit_pht_wen", 32'(pht_wen), 32'd1);
      chk("hit_pht_taken", 32'(pht_taken), 32'd0);
      chk("hit_btb_wen", 32'(btb_wen), 32'd0);
      @(posedge clk);
      #1;

      // Fill while stalled, then release
      upd_stall = 1'b1;
      for (int i = 0; i < 4; i++)
         send(30'(32'h100 + i), 8'(8'h10 + i), 1'b0, 1'(i % 2), 1'b0);
      br_valid = 1'b1;
      br_pc = 30'h105; br_index = 8'h15; br_hit = 1'b0; br_taken = 1'b1; br_mispred = 1'b0;
      @(negedge clk);
      chk("fill_ready_full", 32'(br_ready), 32'd0);
      @(posedge clk);
      #1 upd_stall = 1'b0;
      @(negedge clk);
      chk("fill_no_bypass", 32'(br_ready), 32'd0);
      chk("fill_first_pop", 32'(pht_index), 32'h10);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("fill_ready_after_pop", 32'(br_ready), 32'd1);
      @(posedge clk);
      #1;
      idle(8);

      // Simultaneous push and pop at occupancy 2
      upd_stall = 1'b1;
      send(30'h200, 8'h20, 1'b0, 1'b1, 1'b0);
      send(30'h201, 8'h21, 1'b1, 1'b0, 1'b0);
      upd_stall = 1'b0;
      for (int i = 0; i < 6; i++)
         send(30'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      idle(5);

      // History and restore
      do_reset();
      send(30'h300, 8'h01, 1'b0, 1'b1, 1'b0);
      send(30'h301, 8'h02, 1'b0, 1'b0, 1'b0);
      send(30'h302, 8'h03, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      chk("hist_ghr_05", 32'(ghr_commit), 32'h05);
      @(posedge clk);
      #1;
      send(30'h303, 8'h04, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      chk("restore_valid_pulse", 32'(ghr_restore_valid), 32'd1);
      chk("restore_value_0A", 32'(ghr_restore), 32'h0A);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("restore_pulse_ends", 32'(ghr_restore_valid), 32'd0);
      @(posedge clk);
      #1;
      idle(3);

      // Asynchronous reset with 3 entries queued
      upd_stall = 1'b1;
      send(30'h400, 8'h40, 1'b0, 1'b1, 1'b0);
      send(30'h401, 8'h41, 1'b0, 1'b1, 1'b0);
      send(30'h402, 8'h42, 1'b0, 1'b0, 1'b1);
      upd_stall = 1'b0;
      #2 reset = 1'b1;
      sbq.delete();
      m_ghr = 0;
      m_rv = 1'b0;
      m_restore = 0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_btb_wen", 32'(btb_wen), 32'd0);
      chk("arst_pht_wen", 32'(pht_wen), 32'd0);
      chk("arst_ghr", 32'(ghr_commit), 32'd0);
      chk("arst_br_ready", 32'(br_ready), 32'd1);
      chk("arst_restore_valid", 32'(ghr_restore_valid), 32'd0);
      @(negedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1;
      idle(5);

      // Randomized traffic; an unaccepted branch is held unchanged
      held = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!held) begin
            br_valid   = ($urandom_range(0, 3) != 0);
            br_pc      = 30'($urandom);
            br_index   = 8'($urandom);
            br_hit     = 1'($urandom);
            br_taken   = 1'($urandom);
            br_mispred = ($urandom_range(0, 3) == 0);
         end
         upd_stall = ($urandom_range(0, 2) == 0);
         @(negedge clk);
         #3 held = br_valid && !br_ready;
         @(posedge clk);
         #1;
      end
      upd_stall = 1'b0;
      idle(10);
      chk("final_drained", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
